sequential_multiplier_withregs: RTL and testbench
=================================================

# sequential_multiplier_withregs

Signed 32×32 → 64-bit sequential multiplier with registered inputs and a registered product. It samples its operands every enabled cycle and runs a continuous radix-2 Booth loop, 32 iterations per product. Each result is published in a holding output register, so a new product appears every 33 enabled cycles. It serves as a low-area multiply unit in datapaths that can tolerate a fixed multi-cycle latency.

## Interface
- Parameters: none (widths fixed: 32-bit operands, 64-bit product).
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- a  in  32  signed multiplicand.
- b  in  32  signed multiplier.
- en  in  1  clock enable; when low, all state holds.
- result  out  64  signed product register.
- Positional port order is a, b, clk, reset, en, result.
- done  out  1  present only with SEQMUL_DONE_EN; appended after result.

## Operation
- Input registers a_q and b_q load a and b on every enabled edge.
- Datapath:
  - multiplicand M: 33-bit sign-extended copy of a_q.
  - accumulator A: 33 bits.
  - Q: 32 bits.
  - Booth bit q_1: 1 bit.
  - counter cnt: 5 bits.
- States and transitions:
  - IDLE: entered on reset. Lasts exactly one enabled cycle, during which the input registers fill. Next state is LOAD.
  - LOAD: M ← sext(a_q), Q ← b_q, A ← 0, q_1 ← 0, cnt ← 0. Next state is RUN.
  - RUN: each cycle, decode {Q[0], q_1}:
    - 01: A ← A + M.
    - 10: A ← A − M.
    - 00 or 11: A unchanged.
    - Then arithmetic-shift {A, Q, q_1} right by 1 and increment cnt.
    - On the iteration with cnt == 31, load result with {A[31:0], Q} after the shift, then go to LOAD.
- The loop runs continuously. No start handshake exists; the operands captured in a_q/b_q on the edge before LOAD are the ones multiplied.
- result holds its value until the next completion.
- Arithmetic is exact two's-complement for every input pair, including −2^31 × −2^31 = 2^62. The 33-bit A prevents overflow.

## Timing
- Reset (reset = 0) forces, asynchronously:
  - result = 0, a_q = b_q = 0;
  - A, Q, q_1, cnt = 0;
  - state = IDLE;
  - done = 0.
- First product after reset release: edge 1 IDLE, edge 2 LOAD, edges 3–34 RUN. result updates on enabled edge 34.
- Steady state: one product every 33 enabled edges (1 LOAD + 32 RUN).
- An operand change must be stable before the enabled edge immediately preceding LOAD. A change during RUN does not disturb the product in progress.
- With en = 0, state, counters, input registers and result all freeze. Operation resumes exactly where it stopped.
- Reset asserted mid-operation aborts the product. result clears to 0 immediately, and the sequence restarts from IDLE.
- reset takes priority over en.

## Configuration
- SEQMUL_DONE_EN defined:
  - Adds output done.
  - done is high for exactly one cycle, registered with result, on the edge that updates result.
  - done is 0 while en is low and during reset.
- SEQMUL_DONE_EN undefined: no done port and no associated logic. Behaviour is otherwise identical.

## Test plan
- Reset, then en = 1, a = 5, b = −7 held. → result = 0 until enabled edge 33 after release; result = −35 from edge 34.
- Present a = 2, b = 3, changed after edge 33 and before edge 34. → result = 6 after 33 more edges. Then a = −12, b = −4 → 48, then a = −9, b = 5 → −45.
- a = 11, b = 0 → 0. a = 10, b = 1 → 10. a = 4, b = 6 → 24. a = −1, b = −7 → 7. Each result stays stable for the full 33-cycle window.
- Extremes:
  - a = b = −2^31 → 2^62.
  - a = −2^31, b = 2^31−1 → −2^62 + 2^31.
  - a = b = −1 → 1.
- Drop en for 10 cycles mid-RUN. → result and the completion edge are delayed by exactly 10 cycles, with the product still correct.
- Assert reset mid-RUN. → result = 0 immediately; after release the next valid product appears on enabled edge 34. With SEQMUL_DONE_EN, done pulses once per result update.

Source files
------------

// File: rtl/sequential_multiplier_withregs.sv
// -----------------------------------------------------------------------------
// sequential_multiplier_withregs
//
// Signed 32x32 -> 64-bit sequential multiplier using a continuous radix-2
// Booth loop. Operands are registered every enabled cycle; each product takes
// one LOAD cycle plus 32 RUN iterations and is published in a holding register,
// giving a new product every 33 enabled cycles. There is no start handshake:
// the operands sitting in a_q/b_q when LOAD executes are the ones multiplied.
//
// Ports:
//   a      in  32  signed multiplicand
//   b      in  32  signed multiplier
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-low reset
//   en     in   1  clock enable; when low all state holds
//   result out 64  signed product register, updated on completion
//   done   out  1  one-cycle completion pulse (only with SEQMUL_DONE_EN)
//
// Configuration macro: SEQMUL_DONE_EN adds the done output and its register.
// -----------------------------------------------------------------------------
module sequential_multiplier_withregs (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [63:0] result
`ifdef SEQMUL_DONE_EN
   ,
   output logic        done
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [32:0] m_q;      // sign-extended multiplicand
   logic [32:0] acc_q;    // 33 bits so A - M cannot overflow for -2^31 operands
   logic [31:0] q_q;
   logic        q1_q;
   logic [4:0]  cnt_q;

   logic        do_load;
   logic        do_run;
   logic        do_finish;

   logic [32:0] acc_sum;
   logic [32:0] acc_shift;
   logic [31:0] q_shift;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else if (en) begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment at the top of each combinational block keeps
   // every path assigned, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     if (cnt_q == 5'd31) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output (control) decode
   // ---------------------------------------------------------------------------
   always_comb begin
      do_load   = 1'b0;
      do_run    = 1'b0;
      do_finish = 1'b0;
      case (state)
         LOAD: do_load = 1'b1;
         RUN: begin
            do_run    = 1'b1;
            do_finish = (cnt_q == 5'd31);
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Booth step: add/subtract, then arithmetic shift of {A, Q, q_1}
   // ---------------------------------------------------------------------------
   always_comb begin
      acc_sum = acc_q;
      case ({q_q[0], q1_q})
         2'b01:   acc_sum = acc_q + m_q;
         2'b10:   acc_sum = acc_q - m_q;
         default: acc_sum = acc_q;
      endcase
      acc_shift = {acc_sum[32], acc_sum[32:1]};
      q_shift   = {acc_sum[0], q_q[31:1]};
   end

   // ---------------------------------------------------------------------------
   // Datapath and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         acc_q  <= '0;
         q_q    <= '0;
         q1_q   <= 1'b0;
         cnt_q  <= '0;
         result <= '0;
      end else if (en) begin
         a_q <= a;
         b_q <= b;
         if (do_load) begin
            m_q   <= {a_q[31], a_q};
            acc_q <= '0;
            q_q   <= b_q;
            q1_q  <= 1'b0;
            cnt_q <= '0;
         end else if (do_run) begin
            acc_q <= acc_shift;
            q_q   <= q_shift;
            q1_q  <= q_q[0];
            cnt_q <= cnt_q + 5'd1;
         end
         // Low 64 bits of the shifted {A, Q} form the exact product.
         if (do_finish) begin
            result <= {acc_shift[31:0], q_shift};
         end
      end
   end

`ifdef SEQMUL_DONE_EN
   // Updated on every edge (not gated by en) so the pulse lasts one cycle and
   // is low whenever the completing edge was not enabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done <= 1'b0;
      end else begin
         done <= en && do_finish;
      end
   end
`endif

endmodule

// File: tb/tb_sequential_multiplier_withregs.sv
// -----------------------------------------------------------------------------
// tb_sequential_multiplier_withregs
//
// Directed test of the sequential Booth multiplier: reset state, first-product
// latency, back-to-back products, extreme operands, clock-enable freeze and
// mid-operation reset. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sequential_multiplier_withregs;

   logic [31:0] a;
   logic [31:0] b;
   logic        clk;
   logic        reset;
   logic        en;
   logic [63:0] result;
`ifdef SEQMUL_DONE_EN
   logic        done;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   sequential_multiplier_withregs dut (
      .a      (a),
      .b      (b),
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .result (result)
`ifdef SEQMUL_DONE_EN
      ,
      .done   (done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   // Called just before a completion edge: present the next operands (captured
   // on that edge and used by the following LOAD), clock the completion edge,
   // check the finished product, then run the 32 further edges of the window
   // and confirm the product held.
   task automatic step(input string tag, input logic [31:0] na, input logic [31:0] nb,
                       input logic [63:0] exp_now);
      a = na;
      b = nb;
      tick(1);
      check({tag, "_update"}, result, exp_now);
`ifdef SEQMUL_DONE_EN
      check({tag, "_done_hi"}, {63'd0, done}, 64'd1);
`endif
      tick(32);
      check({tag, "_hold"}, result, exp_now);
`ifdef SEQMUL_DONE_EN
      check({tag, "_done_lo"}, {63'd0, done}, 64'd0);
`endif
   endtask

   localparam logic [31:0] MIN32 = 32'h8000_0000;
   localparam logic [31:0] MAX32 = 32'h7FFF_FFFF;

   initial begin
      reset = 1'b0;
      en    = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      #12;
      check("reset_result", result, 64'd0);

      // First product: a=5, b=-7 held from release.
      a  = 32'd5;
      b  = -32'sd7;
      en = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      tick(33);
      check("first_before_edge34", result, 64'd0);

      step("p_5x-7",   32'd2,          32'd3,          -64'sd35);
      step("p_2x3",    -32'sd12,       -32'sd4,        64'd6);
      step("p_-12x-4", -32'sd9,        32'd5,          64'd48);
      step("p_-9x5",   32'd11,         32'd0,          -64'sd45);
      step("p_11x0",   32'd10,         32'd1,          64'd0);
      step("p_10x1",   32'd4,          32'd6,          64'd10);
      step("p_4x6",    -32'sd1,        -32'sd7,        64'd24);
      step("p_-1x-7",  MIN32,          MIN32,          64'd7);
      step("p_minxmin", MIN32,         MAX32,          64'h4000_0000_0000_0000);
      step("p_minxmax", -32'sd1,       -32'sd1,        64'hC000_0000_8000_0000);
      step("p_-1x-1",  32'd3,          -32'sd5,        64'd1);

      // Enable freeze: operands 7 x 8 go through a 10-cycle en=0 gap mid-RUN.
      a = 32'd7;
      b = 32'd8;
      tick(1);
      check("p_3x-5_update", result, -64'sd15);
      tick(10);
      // Change operands mid-RUN; the product in flight must be unaffected.
      a = -32'sd3;
      b = 32'd9;
      en = 1'b0;
      tick(10);
      check("freeze_hold", result, -64'sd15);
`ifdef SEQMUL_DONE_EN
      check("freeze_done_lo", {63'd0, done}, 64'd0);
`endif
      en = 1'b1;
      tick(22);
      check("freeze_before_completion", result, -64'sd15);
      tick(1);
      check("freeze_7x8", result, 64'd56);
`ifdef SEQMUL_DONE_EN
      check("freeze_done_hi", {63'd0, done}, 64'd1);
`endif

      // Mid-RUN asynchronous reset, asserted between clock edges.
      tick(15);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_clears", result, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      tick(33);
      check("restart_before_edge34", result, 64'd0);
      tick(1);
      check("restart_-3x9", result, -64'sd27);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
